// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with r0 hardwired to zero, optional
// same-cycle write bypass on the operand ports, and an unbypassed debug port.

module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:1][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               byp_en,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W-1:0]                  wdata,
    output logic [DATA_W-1:0]                  data
);
    // Index 0 falls through every compare and reads as zero.
    always_comb begin
        data = '0;
        for (int i = 1; i < 2**ADDR_W; i++)
            if (addr == ADDR_W'(i)) data = regs[i];
        if (byp_en && addr == waddr) data = wdata;
    end
endmodule

module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int PORTS = 3;

    logic [DEPTH-1:1][DATA_W-1:0]  regs;
    logic                          wr_hit;
    logic                          byp_en;
    logic [PORTS-1:0][ADDR_W-1:0]  port_addr;
    logic [PORTS-1:0]              port_byp;
    logic [PORTS-1:0][DATA_W-1:0]  port_data;

    // we gates first so an X waddr with we=0 cannot enable a write.
    assign wr_hit = we && (waddr != '0);
    // Bypass is suppressed in reset so every port reads zero.
    assign byp_en = BYPASS && wr_hit && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            wr_count <= '0;
        end else if (wr_hit) begin
            for (int i = 1; i < DEPTH; i++)
                if (waddr == ADDR_W'(i)) regs[i] <= wdata;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end

    assign port_addr = {dbg_addr, rt_addr, rs_addr};
    assign port_byp  = {1'b0, byp_en, byp_en};

    for (genvar p = 0; p < PORTS; p++) begin : g_rd
        reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
            .regs   (regs),
            .addr   (port_addr[p]),
            .byp_en (port_byp[p]),
            .waddr  (waddr),
            .wdata  (wdata),
            .data   (port_data[p])
        );
    end

    assign rdata_a  = port_data[0];
    assign rdata_b  = port_data[1];
    assign dbg_data = port_data[2];
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- General-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU and supplies its A and B operand buses from the rs/rt fields of the instruction.
- Accepts one write-back per cycle from the ALU result or load path.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Extra debug read port for bench and board inspection.

Parameters:
- DATA_W, 32, width of each register and all data ports
- ADDR_W, 5, register index width; depth = 2**ADDR_W (32 registers)
- BYPASS, 1, 1 = a read of the register being written this cycle returns wdata; 0 = returns the stored (old) value

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rs_addr  input  ADDR_W  read port A index (instr[25:21])
- rt_addr  input  ADDR_W  read port B index (instr[20:16])
- rdata_a  output  DATA_W  register[rs_addr], to ALU input A
- rdata_b  output  DATA_W  register[rt_addr], to ALU input B / store data
- we  input  1  write enable for this cycle
- waddr  input  ADDR_W  write index (rd or rt, already muxed by control)
- wdata  input  DATA_W  write-back data (ALU Res or memory load data)
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  register[dbg_addr]; never bypassed
- wr_count  output  16  count of committed writes since reset, for bench and debug

Behaviour:
Storage and reset:
- Storage is 2**ADDR_W - 1 flops of DATA_W bits (indices 1..N-1); index 0 is not stored.
- rst_n low, at any time: all registers and wr_count clear to 0 immediately, with no clock needed.
- During reset, rdata_a, rdata_b and dbg_data read 0 for every index.
- rst_n is sampled asynchronously.
- Deassertion takes effect on the next rising clk edge; no write commits on an edge where rst_n is low.

Write:
- Commits on the rising clk edge when we=1 and waddr!=0: register[waddr] <= wdata.
- wr_count increments by 1 on that same edge.
- wr_count saturates at 16'hFFFF; no wrap.
- we=1 with waddr=0: no storage change and wr_count unchanged. It is silently ignored, not an error.
- we=0: no state change.

Read:
- rdata_a, rdata_b and dbg_data are combinational from the addresses and storage, with zero latency. A single-cycle CPU requires operands in the same cycle.
- Any read of index 0 returns 0, including when a write to 0 is attempted.
- Bypass (BYPASS=1): when we=1, waddr!=0 and waddr==rs_addr, rdata_a = wdata in the same cycle. The same rule applies independently to rt_addr / rdata_b.
- BYPASS=0: reads return pre-edge storage; the new value is visible starting the cycle after the edge.
- rs_addr==rt_addr: both outputs are identical, and the bypass applies to both.
- dbg_data always reflects committed storage only. It never sees the bypass.

Widths and timing:
- No arithmetic besides wr_count; all data paths are full DATA_W with no extension.
- X on waddr while we=0 must not corrupt state.
- No combinational path from wdata to storage other than through the clk edge.

Test Plan:
- Reset: pulse rst_n low mid-cycle after preloading r5=32'hDEADBEEF -> rdata_a with rs_addr=5 goes to 0 before the next edge, and wr_count=0.
- Basic write/read: write r1=32'h0000_0010, then r2=32'hFFFF_FFF0 on consecutive edges, then rs=1, rt=2 -> rdata_a=32'h10, rdata_b=32'hFFFFFFF0, wr_count=2.
- r0 immunity: we=1, waddr=0, wdata=32'h1234_5678 -> rdata_a with rs_addr=0 stays 0, and wr_count is unchanged.
- Bypass: r3 holds 32'hAAAA_AAAA; drive we=1, waddr=3, wdata=32'h5555_5555 with rs=rt=3 -> before the edge, rdata_a=rdata_b=32'h55555555 with BYPASS=1 (32'hAAAAAAAA with BYPASS=0), and dbg_data with dbg_addr=3 = 32'hAAAAAAAA.
- Reset mid-write: assert rst_n low coincident with we=1, waddr=7, wdata=32'h1 across a clk edge -> r7=0 after release, and wr_count=0.
- Sweep and saturation: write r[i]=i*32'h0101_0101 for i=1..31 and read all back through both ports and dbg -> exact match. Force 65536+ commits -> wr_count holds at 16'hFFFF.
